// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
// Optional feature macro: PROG_SEQ_CALL_STACK_EN (hardware return stack).
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ps_state_t;

    // Source of the next program counter value
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_START  = 3'd1,
        SEL_INC    = 3'd2,
        SEL_TARGET = 3'd3,
        SEL_POP    = 3'd4
    } pc_sel_t;

    // Ceiling log2, valid for value >= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Stack pointer must count 0..depth inclusive, hence one extra bit
    function automatic int sp_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack used by prog_seq when PROG_SEQ_CALL_STACK_EN is defined.
// Top-of-stack read is combinational so a return takes effect on the next edge.
module ret_stack
    import prog_seq_pkg::*;
#(
    parameter int D     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW  = clog2(DEPTH);
    localparam int SPW = sp_width(DEPTH);

    logic [D-1:0]   mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;

    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign wr_idx   = sp_q[AW-1:0];
    assign rd_idx   = wr_idx - AW'(1);
    assign pop_data = mem_q[rd_idx];

    // Pointer update; clear wins, push and pop are never requested together
    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    // Stack pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are don't-care while the pointer says empty
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/prog_seq.sv
// Program sequencer with start/done handshake, stall, halt address and
// optional call/return stack (macro PROG_SEQ_CALL_STACK_EN).
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int D           = 10,
    parameter int START_ADDR  = 0,
    parameter int DONE_ADDR   = 593,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         jb_en,
    input  logic [D-1:0] target,
    input  logic         call,
    input  logic         ret,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         stk_err
);
    ps_state_t    state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] pc_inc;
    pc_sel_t      pc_sel;

    assign pc_inc   = pc_q + D'(1);
    assign prog_ctr = pc_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == HALT);

`ifdef PROG_SEQ_CALL_STACK_EN
    logic         err_q, err_d;
    logic         stk_push, stk_pop, stk_clr;
    logic         stk_full, stk_empty;
    logic [D-1:0] stk_top;

    assign stk_err = err_q;

    ret_stack #(
        .D     (D),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .pop_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    logic unused_ret;
    assign unused_ret = ret;
    assign stk_err    = 1'b0;
`endif

    // Next state, next-PC select and stack controls
    always_comb begin
        state_d = state_q;
        pc_sel  = SEL_HOLD;
`ifdef PROG_SEQ_CALL_STACK_EN
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (req) begin
                    state_d = RUN;
                    pc_sel  = SEL_START;
`ifdef PROG_SEQ_CALL_STACK_EN
                    err_d   = 1'b0;
                    stk_clr = 1'b1;
`endif
                end
            end
            RUN: begin
                // The halt-address instruction is never executed
                if (pc_q == D'(DONE_ADDR)) begin
                    state_d = HALT;
                end else if (!stall) begin
`ifdef PROG_SEQ_CALL_STACK_EN
                    if (ret) begin
                        if (stk_empty) begin
                            pc_sel = SEL_INC;
                            err_d  = 1'b1;
                        end else begin
                            pc_sel  = SEL_POP;
                            stk_pop = 1'b1;
                        end
                    end else if (call) begin
                        pc_sel = SEL_TARGET;
                        if (stk_full) begin
                            err_d = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end else if (jb_en) begin
                        pc_sel = SEL_TARGET;
                    end else begin
                        pc_sel = SEL_INC;
                    end
`else
                    if (call || jb_en) begin
                        pc_sel = SEL_TARGET;
                    end else begin
                        pc_sel = SEL_INC;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                pc_sel  = SEL_START;
            end
        endcase
    end

    // Program counter multiplexer
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            SEL_START:  pc_d = D'(START_ADDR);
            SEL_INC:    pc_d = pc_inc;
            SEL_TARGET: pc_d = target;
`ifdef PROG_SEQ_CALL_STACK_EN
            SEL_POP:    pc_d = stk_top;
`endif
            default:    pc_d = pc_q;
        endcase
    end

    // State, program counter and error flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= D'(START_ADDR);
`ifdef PROG_SEQ_CALL_STACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PROG_SEQ_CALL_STACK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_seq.sv
// Directed self-checking bench for prog_seq (D=10, START_ADDR=0,
// DONE_ADDR=60, STACK_DEPTH=2). Expectations follow PROG_SEQ_CALL_STACK_EN.
module tb_prog_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, stall, jb_en, call, ret;
    logic [9:0] target;
    logic [9:0] prog_ctr;
    logic       running, done, stk_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req;
        logic       stall;
        logic       jb;
        logic [9:0] tgt;
        logic [9:0] pc;
        logic       run;
        logic       dn;
    } vec_t;

    vec_t tbl [17];

    prog_seq #(
        .D           (10),
        .START_ADDR  (0),
        .DONE_ADDR   (60),
        .STACK_DEPTH (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .stall    (stall),
        .jb_en    (jb_en),
        .target   (target),
        .call     (call),
        .ret      (ret),
        .prog_ctr (prog_ctr),
        .running  (running),
        .done     (done),
        .stk_err  (stk_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk(input string name, input int pc, input int run,
                       input int dn, input int err);
        cmp({name, ".pc"}, int'(prog_ctr), pc);
        cmp({name, ".running"}, int'(running), run);
        cmp({name, ".done"}, int'(done), dn);
        cmp({name, ".stk_err"}, int'(stk_err), err);
        $display("%-12s pc=%0d running=%0b done=%0b stk_err=%0b",
                 name, prog_ctr, running, done, stk_err);
    endtask

    // Drive one cycle of controls, clock it, then check the registered result
    task automatic step(input string name, input logic r, input logic s,
                        input logic j, input logic c, input logic rt,
                        input logic [9:0] t, input int pc, input int run,
                        input int dn, input int err);
        req = r; stall = s; jb_en = j; call = c; ret = rt; target = t;
        tick();
        chk(name, pc, run, dn, err);
    endtask

    initial begin
        //            req   stall jb    tgt     pc      run   done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd1,    1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd2,    1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd3,    1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 10'd0,    10'd3,    1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 10'd20,   10'd3,    1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'd0,    10'd3,    1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd4,    1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 10'd58,   10'd58,   1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd59,   1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd60,   1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 10'd0,    10'd60,   1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 10'd5,    10'd60,   1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 10'd0,    10'd1,    1'b1, 1'b0};

        reset = 1'b1; req = 1'b1; stall = 1'b0; jb_en = 1'b0;
        call = 1'b0; ret = 1'b0; target = '0;

        // Reset held with req high: nothing may start
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d", i), 0, 0, 0, 0);
        end
        reset = 1'b0;
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 0, 0, 0, 0);

        // Table: count, stall, halt, restart, wrap
        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), tbl[i].req, tbl[i].stall, tbl[i].jb,
                 1'b0, 1'b0, tbl[i].tgt, int'(tbl[i].pc), int'(tbl[i].run),
                 int'(tbl[i].dn), 0);
        end

`ifdef PROG_SEQ_CALL_STACK_EN
        step("jmp10",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd10,  10,  1, 0, 0);
        step("call40", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd40,  40,  1, 0, 0);
        step("inc41",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   41,  1, 0, 0);
        step("inc42",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   42,  1, 0, 0);
        step("ret11",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   11,  1, 0, 0);
        step("call100",1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 100, 1, 0, 0);
        step("call200",1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd200, 200, 1, 0, 0);
        step("ovf300", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd300, 300, 1, 0, 1);
        step("ret101", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   101, 1, 0, 1);
        step("ret12",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   12,  1, 0, 1);
        step("unf13",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   13,  1, 0, 1);
        step("jmp7",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd7,   7,   1, 0, 1);
        step("unf8",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   8,   1, 0, 1);
        step("callret",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd30,  9,   1, 0, 1);
        step("nopush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   10,  1, 0, 1);
        step("call50", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd50,  50,  1, 0, 1);
        step("jmp58",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd58,  58,  1, 0, 1);
        step("inc59",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   59,  1, 0, 1);
        step("inc60",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   60,  1, 0, 1);
        step("halt",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   60,  0, 1, 1);
        step("restart",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   0,   1, 0, 0);
        step("emptied",1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   1,   1, 0, 1);
`else
        step("jmp10",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd10,  10,  1, 0, 0);
        step("call40", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd40,  40,  1, 0, 0);
        step("inc41",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   41,  1, 0, 0);
        step("ret42",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   42,  1, 0, 0);
        step("callret",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd30,  30,  1, 0, 0);
        step("stallc", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5,   30,  1, 0, 0);
`endif

        // Asynchronous reset mid-run must act before the next edge
        req = 1'b0; stall = 1'b0; jb_en = 1'b0; call = 1'b0; ret = 1'b0;
        reset = 1'b1;
        #2;
        chk("async_rst", 0, 0, 0, 0);
        tick();
        chk("rst_hold", 0, 0, 0, 0);
        reset = 1'b0;
        step("post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 0, 0, 0, 0);
        step("post_req",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 0, 1, 0, 0);
        step("post_inc",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer for the 9-bit accumulator-style core. It replaces the free-running program counter and the hard-wired completion compare with a start/done handshake. It adds stall support, a configurable halt address and an optional hardware call/return stack. It sits between the control/LUT logic (which supplies `target`, `jb_en`, `call` and `ret`) and `instr_ROM` (driven by `prog_ctr`).

## Interface
- `D`, 10, program counter width in bits
- `START_ADDR`, 0, first instruction address after a start request
- `DONE_ADDR`, 593, halt address; reaching it ends the program
- `STACK_DEPTH`, 4, return-stack entries (power of two, at least 2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; all state cleared immediately
- `req`  in  1  start pulse; sampled in IDLE or HALT
- `stall`  in  1  freeze `prog_ctr`, stack and state for this cycle
- `jb_en`  in  1  taken branch/jump this cycle
- `target`  in  D  branch/jump/call destination from LUT
- `call`  in  1  jump to `target` and push return address
- `ret`  in  1  pop return address into `prog_ctr`
- `prog_ctr`  out  D  current instruction address
- `running`  out  1  high in RUN
- `done`  out  1  high in HALT
- `stk_err`  out  1  sticky stack overflow/underflow flag

## Operation
- FSM states: IDLE, RUN, HALT. Reset gives IDLE, `prog_ctr`=START_ADDR, stack pointer 0, `running`=0, `done`=0, `stk_err`=0.
- IDLE: `req`=1 moves to RUN; `prog_ctr` stays START_ADDR.
- RUN: if `prog_ctr`==DONE_ADDR, move to HALT next cycle. The instruction at DONE_ADDR is not executed, and controls and `stall` are ignored that cycle. Otherwise, if `stall`=1, hold everything.
- RUN next-PC priority, highest first:
  - `ret`: pop into `prog_ctr`.
  - `call`: push `prog_ctr`+1 and load `target`. `jb_en` is don't-care.
  - `jb_en`: load `target`.
  - None of the above: `prog_ctr`+1, wrapping modulo 2^D.
- `call` and `ret` asserted together: `ret` wins and `call` is dropped. No push occurs.
- Overflow: a `call` with the stack full still jumps to `target`, discards the push and sets `stk_err`.
- Underflow: a `ret` with the stack empty loads `prog_ctr`+1 and sets `stk_err`.
- HALT: `prog_ctr` holds DONE_ADDR. `req`=1 returns to RUN with `prog_ctr`=START_ADDR.
- A `req` accepted from IDLE or HALT clears `stk_err` and empties the stack.
- `req` in RUN is ignored.
- Asynchronous `reset` in any state, including mid-program, returns immediately to the reset values.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `req` at edge N: `running`=1 after edge N. The first fetch address (START_ADDR) is valid during cycle N+1.
- Branch, call and ret take effect at the next edge (zero bubble).
- `prog_ctr`==DONE_ADDR seen at edge M: `done`=1 and `running`=0 after edge M.
- `done` stays high until `req` or `reset`; it deasserts on the edge that accepts `req`.
- `stk_err` rises on the edge that performs the faulting call or ret.

## Configuration
- Macro `PROG_SEQ_CALL_STACK_EN`.
- Defined: return stack of STACK_DEPTH entries, with the `call`/`ret` behaviour and `stk_err` as above.
- Undefined: no stack storage is instantiated. `call` is treated exactly as `jb_en`, `ret` is ignored, and `stk_err` is tied to 0. Port list is unchanged.

## Structure
- Package `prog_seq_pkg` holds:
  - the state enum `ps_state_t` {IDLE, RUN, HALT}
  - the next-PC select enum
  - `function automatic clog2`-based stack pointer width derived from STACK_DEPTH
- Sub-module `ret_stack`, present only under the macro. It is a LIFO with push/pop/full/empty, STACK_DEPTH×D storage, and uses the same `clk`/`reset`. Simultaneous push and pop cannot occur, because `ret` priority is resolved in `prog_seq`.

## Test plan
- Reset with `req` high: `prog_ctr`=0, `done`=0 throughout reset. After release and one `req` pulse, `prog_ctr` counts 0,1,2,…
- DONE_ADDR=5, no branches, `req` at cycle 0: `prog_ctr` sequence 0–5, then `done`=1 and `prog_ctr` holds 5. A second `req` restarts at 0 and `done` drops.
- `stall`=1 for 3 cycles at `prog_ctr`=3: value 3 held for 3 cycles, then 4. A `jb_en` to 20 asserted under stall is ignored.
- `call` `target`=40 at PC 10, then `ret` at PC 42: PC sequence 10, 40, 41, 42, 11.
- STACK_DEPTH=2, three nested calls: third call still jumps and `stk_err`=1. A `ret` on an empty stack at PC 7 gives PC 8. `req` from HALT clears `stk_err`.
- Without macro: `call` `target`=40 at PC 10 gives 40; `ret` at 41 gives 42; `stk_err` stays 0. Asynchronous `reset` mid-run returns to IDLE, PC=START_ADDR before the next edge.
